// File: rtl/ttl_555_tone_env_if.sv
// ttl_555_tone_env_if: trigger/tone inputs and envelope/audio outputs of one tone envelope channel
interface ttl_555_tone_env_if #(
  parameter int ENV_W   = 8,
  parameter int AUDIO_W = 16
);
  logic                      trigger;
  logic                      tone_in;
  logic                      active;
  logic [ENV_W-1:0]          env_level;
  logic signed [AUDIO_W-1:0] audio_out;
  modport master (output trigger, tone_in, input active, env_level, audio_out);
  modport slave  (input trigger, tone_in, output active, env_level, audio_out);
endinterface

// File: rtl/ttl_555_tone_env.sv
// ttl_555_tone_env: gates a 555 square wave with a triggered hold/decay envelope into signed audio
module ttl_555_tone_env #(
  parameter int AUDIO_W           = 16,
  parameter int ENV_W             = 8,
  parameter int HOLD_COUNTS       = 48000,
  parameter int DECAY_STEP_COUNTS = 256
) (
  input logic                clk,
  input logic                reset,
  ttl_555_tone_env_if.slave  bus
);
  localparam int SHIFT = AUDIO_W - 1 - ENV_W;
  localparam int HW    = (HOLD_COUNTS > 1) ? $clog2(HOLD_COUNTS) : 1;
  localparam int SW    = (DECAY_STEP_COUNTS > 1) ? $clog2(DECAY_STEP_COUNTS) : 1;
  localparam logic [ENV_W-1:0] ENV_MAX = '1;
  if (AUDIO_W < ENV_W + 1) begin : g_bad_width
    $error("AUDIO_W must be at least ENV_W+1");
  end
  typedef enum logic [1:0] {IDLE, HOLD, DECAY} state_t;
  state_t              state, state_n;
  logic [ENV_W-1:0]    env, env_n;
  logic [HW-1:0]       hold_cnt, hold_n;
  logic [SW-1:0]       step_cnt, step_n;
  logic                trig_d, trig_edge;
  logic [AUDIO_W-1:0]  mag, audio, audio_n;
  assign trig_edge     = bus.trigger & ~trig_d;
  assign mag           = AUDIO_W'(env) << SHIFT;
  assign audio_n       = bus.tone_in ? mag : -mag;
  assign bus.active    = state != IDLE;
  assign bus.env_level = env;
  assign bus.audio_out = audio;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      env      <= '0;
      hold_cnt <= '0;
      step_cnt <= '0;
      trig_d   <= 1'b0;
      audio    <= '0;
    end else begin
      state    <= state_n;
      env      <= env_n;
      hold_cnt <= hold_n;
      step_cnt <= step_n;
      trig_d   <= bus.trigger;
      audio    <= audio_n;
    end
  end
  // a new edge restarts the envelope ahead of any hold-end or decay-step event
  always_comb begin
    state_n = state;
    env_n   = env;
    hold_n  = hold_cnt;
    step_n  = step_cnt;
    if (trig_edge) begin
      state_n = HOLD;
      env_n   = ENV_MAX;
      hold_n  = '0;
      step_n  = '0;
    end else if (state == HOLD) begin
      hold_n  = hold_cnt + 1'b1;
      state_n = (hold_cnt == HW'(HOLD_COUNTS - 1)) ? DECAY : HOLD;
      step_n  = '0;
    end else if (state == DECAY) begin
      step_n  = (step_cnt == SW'(DECAY_STEP_COUNTS - 1)) ? '0 : step_cnt + 1'b1;
      env_n   = (step_cnt == SW'(DECAY_STEP_COUNTS - 1)) ? env - 1'b1 : env;
      state_n = (step_cnt == SW'(DECAY_STEP_COUNTS - 1) && env == ENV_W'(1)) ? IDLE : DECAY;
    end else begin
      env_n   = '0;
    end
  end
endmodule

// File: tb/tb_ttl_555_tone_env.sv
// tb_ttl_555_tone_env: directed checks of envelope timing, retrigger, audio polarity and reset
module tb_ttl_555_tone_env;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   act_cnt = 0;
  ttl_555_tone_env_if #(.ENV_W(4), .AUDIO_W(8)) ifc ();
  ttl_555_tone_env #(
    .AUDIO_W(8), .ENV_W(4), .HOLD_COUNTS(4), .DECAY_STEP_COUNTS(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(ifc.slave)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_active"}, {31'h0, ifc.active}, 32'h0);
    chk({tag, "_env"},    {28'h0, ifc.env_level}, 32'h0);
    chk({tag, "_audio"},  {24'h0, ifc.audio_out}, 32'h0);
  endtask
  // j counts cycles after the sampling edge: 4 hold cycles, then one LSB every 2 cycles
  task automatic run_env(input int start, input int n, input string tag);
    for (int j = start; j < start + n; j++) begin
      chk({tag, "_env"}, {28'h0, ifc.env_level}, (j < 4) ? 32'd15 : (j < 34) ? 32'(15 - (j - 4) / 2) : 32'd0);
      chk({tag, "_active"}, {31'h0, ifc.active}, (j < 34) ? 32'd1 : 32'd0);
      if (ifc.active) act_cnt++;
      step();
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    reset = 1'b1; ifc.trigger = 1'b1; ifc.tone_in = 1'b1;
    repeat (3) begin
      step();
      chk_zero("t1_reset");
    end
    reset = 1'b0;
    step();
    chk("t1_release_env", {28'h0, ifc.env_level}, 32'd15);
    chk("t1_release_active", {31'h0, ifc.active}, 32'd1);
    reset = 1'b1; ifc.trigger = 1'b0;
    step();
    chk_zero("t1_rereset");
    reset = 1'b0;
    step(); step();
    ifc.trigger = 1'b1; step(); ifc.trigger = 1'b0;
    chk("t2_audio_lag", {24'h0, ifc.audio_out}, 32'h00);
    act_cnt = 0;
    run_env(0, 1, "t2");
    chk("t2_audio_peak", {24'h0, ifc.audio_out}, 32'h78);
    run_env(1, 36, "t2");
    chk("t2_active_count", act_cnt, 32'd34);
    chk("t2_audio_idle", {24'h0, ifc.audio_out}, 32'h00);
    ifc.trigger = 1'b1; step(); ifc.trigger = 1'b0;
    ifc.tone_in = 1'b0; step();
    chk("t3_neg15", {24'h0, ifc.audio_out}, 32'h88);
    ifc.tone_in = 1'b1; step();
    chk("t3_pos15", {24'h0, ifc.audio_out}, 32'h78);
    ifc.tone_in = 1'b0; step();
    chk("t3_neg15b", {24'h0, ifc.audio_out}, 32'h88);
    repeat (29) step();
    chk("t3_env1", {28'h0, ifc.env_level}, 32'd1);
    ifc.tone_in = 1'b1; step();
    chk("t3_pos1", {24'h0, ifc.audio_out}, 32'h08);
    ifc.tone_in = 1'b0; step();
    chk("t3_neg1", {24'h0, ifc.audio_out}, 32'hF8);
    chk("t3_env0", {28'h0, ifc.env_level}, 32'd0);
    chk("t3_idle", {31'h0, ifc.active}, 32'd0);
    step();
    chk("t3_audio0", {24'h0, ifc.audio_out}, 32'h00);
    ifc.tone_in = 1'b1;
    ifc.trigger = 1'b1; step(); ifc.trigger = 1'b0;
    act_cnt = 0;
    run_env(0, 16, "t4a");
    chk("t4_env9", {28'h0, ifc.env_level}, 32'd9);
    ifc.trigger = 1'b1; step(); ifc.trigger = 1'b0;
    run_env(0, 36, "t4b");
    chk("t4_active_count", act_cnt, 32'd50);
    ifc.trigger = 1'b1; step(); ifc.trigger = 1'b0;
    run_env(0, 3, "t4c");
    ifc.trigger = 1'b1; step(); ifc.trigger = 1'b0;
    run_env(0, 36, "t4d");
    ifc.trigger = 1'b1; step();
    act_cnt = 0;
    run_env(0, 100, "t5");
    chk("t5_active_count", act_cnt, 32'd34);
    ifc.trigger = 1'b0; step();
    ifc.trigger = 1'b1; step(); ifc.trigger = 1'b0;
    chk("t5_rearm_env", {28'h0, ifc.env_level}, 32'd15);
    step();
    reset = 1'b1; step();
    chk_zero("t6_hold_reset");
    reset = 1'b0;
    repeat (3) step();
    chk_zero("t6_hold_after");
    ifc.trigger = 1'b1; step(); ifc.trigger = 1'b0;
    run_env(0, 10, "t6");
    chk("t6_env12", {28'h0, ifc.env_level}, 32'd12);
    reset = 1'b1; step();
    chk_zero("t6_decay_reset");
    reset = 1'b0;
    repeat (3) step();
    chk_zero("t6_decay_after");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
